// File: rtl/layer_serializer.sv
// layer_serializer: turns one layer's parallel neuron outputs into the serial
// valid/data stream for the next layer. Each frame is followed by an idle gap
// so that downstream neurons can drain and rearm. One vector can be held
// pending while a frame is in flight.
module layer_serializer #(
  parameter  int numNeurons = 30,
  parameter  int dataWidth  = 16,
  parameter  int minGap     = 8,
  localparam int idxWidth   = $clog2(numNeurons)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             layer_in_valid,
  input  logic [numNeurons*dataWidth-1:0]  layer_in,
  output logic                             out_valid,
  output logic [dataWidth-1:0]             out_data,
  output logic [idxWidth-1:0]              out_index,
  output logic                             out_last,
  output logic                             busy,
  output logic                             drop
);

  localparam int gapWidth = $clog2(minGap + 1);
  localparam logic [idxWidth-1:0] last_idx = idxWidth'(numNeurons - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state, state_d;
  logic [gapWidth-1:0]   gap_cnt, gap_d;
  logic                  pend_full, pend_full_d, pend_free;
  logic                  valid_d, last_d, busy_d, drop_d;
  logic [dataWidth-1:0]  data_d;
  logic [idxWidth-1:0]   index_d, next_index;
  logic                  load_active_in, load_active_pend, load_pend;

  logic [dataWidth-1:0]  in_elem    [numNeurons];
  logic [dataWidth-1:0]  active_buf [numNeurons];
  logic [dataWidth-1:0]  pend_buf   [numNeurons];

  // Unpack the flat input bus into elements.
  for (genvar g = 0; g < numNeurons; g++) begin : g_unpack
    assign in_elem[g] = layer_in[g*dataWidth +: dataWidth];
  end

  assign next_index = out_index + 1'b1;

  // Next-state, next-output and buffer-control decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d          = state;
    gap_d            = gap_cnt;
    pend_full_d      = pend_full;
    pend_free        = !pend_full;
    valid_d          = 1'b0;
    last_d           = 1'b0;
    drop_d           = 1'b0;
    data_d           = out_data;
    index_d          = out_index;
    load_active_in   = 1'b0;
    load_active_pend = 1'b0;
    load_pend        = 1'b0;

    unique case (state)
      IDLE: begin
        if (layer_in_valid) begin
          load_active_in = 1'b1;
          state_d        = SHIFT;
          valid_d        = 1'b1;
          index_d        = '0;
          data_d         = in_elem[0];
        end
      end
      SHIFT: begin
        if (out_index == last_idx) begin
          state_d = GAP;
          gap_d   = gapWidth'(minGap);
        end else begin
          valid_d = 1'b1;
          index_d = next_index;
          data_d  = active_buf[next_index];
          last_d  = (next_index == last_idx);
        end
      end
      GAP: begin
        if (gap_cnt == gapWidth'(1)) begin
          gap_d = '0;
          if (pend_full) begin
            // Pending vector becomes active; its slot is free this same cycle.
            load_active_pend = 1'b1;
            pend_free        = 1'b1;
            pend_full_d      = 1'b0;
            state_d          = SHIFT;
            valid_d          = 1'b1;
            index_d          = '0;
            data_d           = pend_buf[0];
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A vector arriving while a frame is in flight goes to pending or is dropped.
    if (state != IDLE && layer_in_valid) begin
      if (pend_free) begin
        load_pend   = 1'b1;
        pend_full_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE) || pend_full_d;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      pend_full <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_d;
      gap_cnt   <= gap_d;
      pend_full <= pend_full_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_index <= index_d;
      out_last  <= last_d;
      busy      <= busy_d;
      drop      <= drop_d;
    end
  end

  // Active and pending vector storage.
  // NOTE: data buffers carry no reset; pend_full and state gate every read.
  always_ff @(posedge clk) begin
    if (load_active_in) begin
      active_buf <= in_elem;
    end else if (load_active_pend) begin
      active_buf <= pend_buf;
    end
    if (load_pend) begin
      pend_buf <= in_elem;
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer with 4 elements, 16-bit data, gap of 3.
module tb_layer_serializer;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int MG = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              layer_in_valid = 1'b0;
  logic [NN*DW-1:0]  layer_in = '0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_index;
  logic              out_last;
  logic              busy;
  logic              drop;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  layer_serializer #(.numNeurons(NN), .dataWidth(DW), .minGap(MG)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .layer_in_valid (layer_in_valid),
    .layer_in       (layer_in),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last),
    .busy           (busy),
    .drop           (drop)
  );

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    layer_in_valid = 1'b0;
    layer_in = '0;
    sync();
    sync();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sync();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h want 0000", out_data); end
    n_cmp++; if (out_index !== 2'd0) begin n_fail++; $display("FAIL rst_index got %0d want 0", out_index); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rst_drop got %b want 0", drop); end
    rst_n = 1'b1;
    sync();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle got v=%b b=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_single();
    logic [NN*DW-1:0] vec;
    logic [DW-1:0] ed;
    logic [IW-1:0] ei;
    logic ev, el, eb;
    vec = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    ed = '0; ei = '0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      layer_in_valid = (c == 0);
      layer_in = vec;
      @(negedge clk);
      ev = (c >= 1 && c <= 4);
      if (ev) begin ed = vec[(c-1)*DW +: DW]; ei = IW'(c-1); end
      el = (c == 4);
      eb = (c >= 1 && c <= 7);
      n_cmp++; if (out_valid !== ev) begin n_fail++; $display("FAIL single_valid c=%0d got %b want %b", c, out_valid, ev); end
      n_cmp++; if (out_data !== ed) begin n_fail++; $display("FAIL single_data c=%0d got %h want %h", c, out_data, ed); end
      n_cmp++; if (out_index !== ei) begin n_fail++; $display("FAIL single_index c=%0d got %0d want %0d", c, out_index, ei); end
      n_cmp++; if (out_last !== el) begin n_fail++; $display("FAIL single_last c=%0d got %b want %b", c, out_last, el); end
      n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL single_busy c=%0d got %b want %b", c, busy, eb); end
      n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL single_drop c=%0d got %b want 0", c, drop); end
      sync();
    end
    layer_in_valid = 1'b0;
  endtask

  // Shared by the pending and overflow scenarios: A at 0, B at b_cyc, optional C at c_cyc.
  task automatic test_pending(input bit with_c);
    logic [NN*DW-1:0] va, vb, vc;
    logic [DW-1:0] ed;
    logic ev, el, eb, edr;
    va = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    vb = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    vc = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    ed = '0;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      if (with_c) begin
        layer_in_valid = (c <= 2);
        layer_in = (c == 0) ? va : (c == 1) ? vb : vc;
      end else begin
        layer_in_valid = (c == 0 || c == 2);
        layer_in = (c == 0) ? va : vb;
      end
      @(negedge clk);
      ev = (c >= 1 && c <= 4) || (c >= 8 && c <= 11);
      if (c >= 1 && c <= 4) ed = va[(c-1)*DW +: DW];
      if (c >= 8 && c <= 11) ed = vb[(c-8)*DW +: DW];
      el = (c == 4 || c == 11);
      eb = (c >= 1 && c <= 14);
      edr = with_c && (c == 3);
      n_cmp++; if (out_valid !== ev) begin n_fail++; $display("FAIL pend%0d_valid c=%0d got %b want %b", with_c, c, out_valid, ev); end
      n_cmp++; if (out_data !== ed) begin n_fail++; $display("FAIL pend%0d_data c=%0d got %h want %h", with_c, c, out_data, ed); end
      n_cmp++; if (out_last !== el) begin n_fail++; $display("FAIL pend%0d_last c=%0d got %b want %b", with_c, c, out_last, el); end
      n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL pend%0d_busy c=%0d got %b want %b", with_c, c, busy, eb); end
      n_cmp++; if (drop !== edr) begin n_fail++; $display("FAIL pend%0d_drop c=%0d got %b want %b", with_c, c, drop, edr); end
      sync();
    end
    layer_in_valid = 1'b0;
  endtask

  task automatic test_slot_free();
    logic [NN*DW-1:0] va, vb, vc;
    logic [DW-1:0] ed;
    logic [IW-1:0] ei;
    logic ev, el, eb;
    va = {16'h1103, 16'h1102, 16'h1101, 16'h1100};
    vb = {16'h2203, 16'h2202, 16'h2201, 16'h2200};
    vc = {16'h3303, 16'h3302, 16'h3301, 16'h3300};
    ed = '0; ei = '0;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      layer_in_valid = (c == 0 || c == 1 || c == 7);
      layer_in = (c == 0) ? va : (c == 1) ? vb : vc;
      @(negedge clk);
      ev = (c >= 1 && c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18);
      if (c >= 1 && c <= 4)   begin ed = va[(c-1)*DW +: DW];  ei = IW'(c-1);  end
      if (c >= 8 && c <= 11)  begin ed = vb[(c-8)*DW +: DW];  ei = IW'(c-8);  end
      if (c >= 15 && c <= 18) begin ed = vc[(c-15)*DW +: DW]; ei = IW'(c-15); end
      el = (c == 4 || c == 11 || c == 18);
      eb = (c >= 1 && c <= 21);
      n_cmp++; if (out_valid !== ev) begin n_fail++; $display("FAIL slot_valid c=%0d got %b want %b", c, out_valid, ev); end
      n_cmp++; if (out_data !== ed) begin n_fail++; $display("FAIL slot_data c=%0d got %h want %h", c, out_data, ed); end
      n_cmp++; if (out_index !== ei) begin n_fail++; $display("FAIL slot_index c=%0d got %0d want %0d", c, out_index, ei); end
      n_cmp++; if (out_last !== el) begin n_fail++; $display("FAIL slot_last c=%0d got %b want %b", c, out_last, el); end
      n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL slot_busy c=%0d got %b want %b", c, busy, eb); end
      n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL slot_drop c=%0d got %b want 0", c, drop); end
      sync();
    end
    layer_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [NN*DW-1:0] va, vd;
    va = {16'h5503, 16'h5502, 16'h5501, 16'h5500};
    vd = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    apply_reset();
    layer_in_valid = 1'b1;
    layer_in = va;
    sync();
    layer_in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h5500) begin n_fail++; $display("FAIL rmid_first got v=%b d=%h want 1 5500", out_valid, out_data); end
    sync();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (out_index !== 2'd0 || out_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_clear got i=%0d d=%h want 0 0000", out_index, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_noresume got v=%b b=%b want 0 0", out_valid, busy); end
    sync();
    layer_in_valid = 1'b1;
    layer_in = vd;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_cap got %b want 0", out_valid); end
    sync();
    layer_in_valid = 1'b0;
    for (int e = 0; e < NN; e++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_d_valid e=%0d got %b want 1", e, out_valid); end
      n_cmp++; if (out_data !== vd[e*DW +: DW]) begin n_fail++; $display("FAIL rmid_d_data e=%0d got %h want %h", e, out_data, vd[e*DW +: DW]); end
      n_cmp++; if (out_index !== IW'(e)) begin n_fail++; $display("FAIL rmid_d_index e=%0d got %0d want %0d", e, out_index, e); end
      n_cmp++; if (out_last !== (e == NN-1)) begin n_fail++; $display("FAIL rmid_d_last e=%0d got %b want %b", e, out_last, (e == NN-1)); end
      sync();
    end
  endtask

  task automatic test_signed();
    logic [DW-1:0] expv [NN];
    expv = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      layer_in_valid = (c == 0);
      layer_in = {16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL signed_valid c=%0d got %b want 1", c, out_valid); end
        n_cmp++; if (out_data !== expv[c-1]) begin n_fail++; $display("FAIL signed_data c=%0d got %h want %h", c, out_data, expv[c-1]); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL signed_idle c=%0d got %b want 0", c, out_valid); end
      end
      sync();
    end
    layer_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_pending(1'b0);
    test_pending(1'b1);
    test_slot_free();
    test_reset_mid();
    test_signed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
